// File: rtl/dp_sync_ram_if.sv
// Bus bundle for dp_sync_ram: two access ports plus status flags.
interface dp_sync_ram_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
);
  logic              en_a;
  logic              we_a;
  logic [ADDR_W-1:0] addr_a;
  logic [DATA_W-1:0] din_a;
  logic [DATA_W-1:0] dout_a;
  logic              vld_a;

  logic              en_b;
  logic              we_b;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] din_b;
  logic [DATA_W-1:0] dout_b;
  logic              vld_b;

  logic              busy;
  logic              coll;

  modport master (
    output en_a, we_a, addr_a, din_a,
    output en_b, we_b, addr_b, din_b,
    input  dout_a, vld_a, dout_b, vld_b, busy, coll
  );

  modport slave (
    input  en_a, we_a, addr_a, din_a,
    input  en_b, we_b, addr_b, din_b,
    output dout_a, vld_a, dout_b, vld_b, busy, coll
  );
endinterface

// File: rtl/dp_sync_ram.sv
// True dual-port synchronous RAM with post-reset clear sequence, selectable
// same-port read-during-write behaviour and optional output register.
module dp_sync_ram #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned RD_MODE = 0,
  parameter int unsigned OUT_REG = 0
) (
  input  logic         clk,
  input  logic         rst,
  dp_sync_ram_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic {StClear, StRun} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              run;
  logic              acc_a, acc_b;
  logic              wr_a, wr_b;
  logic              same_addr;
  logic [DATA_W-1:0] rd_a, rd_b;

  logic              vld1_a_q, vld1_b_q;
  logic [DATA_W-1:0] rd1_a_q, rd1_b_q;
  logic              coll_q;

  // Next-state: walk the clear counter through every address, then run forever.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      StClear: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == {ADDR_W{1'b1}}) begin
          state_d = StRun;
        end
      end
      StRun:   state_d = StRun;
      default: state_d = StClear;
    endcase
  end

  // State register and clear counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StClear;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  assign run       = (state_q == StRun);
  assign acc_a     = run & bus.en_a;
  assign acc_b     = run & bus.en_b;
  assign wr_a      = acc_a & bus.we_a;
  assign wr_b      = acc_b & bus.we_b;
  assign same_addr = (bus.addr_a == bus.addr_b);

  // Array reads return the pre-edge word, so cross-port reads always see old data;
  // only a same-port write in write-first mode forwards the incoming data.
  assign rd_a = (RD_MODE != 0 && wr_a) ? bus.din_a : mem[bus.addr_a];
  assign rd_b = (RD_MODE != 0 && wr_b) ? bus.din_b : mem[bus.addr_b];

  // Storage: zero-fill during clear; in run port A wins a same-address collision.
  always_ff @(posedge clk) begin
    if (!run) begin
      mem[clr_cnt_q] <= '0;
    end else begin
      if (wr_b && !(wr_a && same_addr)) begin
        mem[bus.addr_b] <= bus.din_b;
      end
      if (wr_a) begin
        mem[bus.addr_a] <= bus.din_a;
      end
    end
  end

  // First read stage: data only loads on an access so it holds between reads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld1_a_q <= 1'b0;
      vld1_b_q <= 1'b0;
      rd1_a_q  <= '0;
      rd1_b_q  <= '0;
      coll_q   <= 1'b0;
    end else begin
      vld1_a_q <= acc_a;
      vld1_b_q <= acc_b;
      if (acc_a) rd1_a_q <= rd_a;
      if (acc_b) rd1_b_q <= rd_b;
      coll_q   <= wr_a & wr_b & same_addr;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic              vld2_a_q, vld2_b_q;
      logic [DATA_W-1:0] rd2_a_q, rd2_b_q;

      // Optional second stage, same hold-on-idle behaviour as the first.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          vld2_a_q <= 1'b0;
          vld2_b_q <= 1'b0;
          rd2_a_q  <= '0;
          rd2_b_q  <= '0;
        end else begin
          vld2_a_q <= vld1_a_q;
          vld2_b_q <= vld1_b_q;
          if (vld1_a_q) rd2_a_q <= rd1_a_q;
          if (vld1_b_q) rd2_b_q <= rd1_b_q;
        end
      end

      assign bus.dout_a = rd2_a_q;
      assign bus.vld_a  = vld2_a_q;
      assign bus.dout_b = rd2_b_q;
      assign bus.vld_b  = vld2_b_q;
    end else begin : g_no_out_reg
      assign bus.dout_a = rd1_a_q;
      assign bus.vld_a  = vld1_a_q;
      assign bus.dout_b = rd1_b_q;
      assign bus.vld_b  = vld1_b_q;
    end
  endgenerate

  assign bus.busy = ~run;
  assign bus.coll = coll_q;

endmodule

// File: doc/dp_sync_ram.md
DP_SYNC_RAM -- requirements
Module: dp_sync_ram

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- DATA_W, 8: word width in bits.
- ADDR_W, 4: address width; DEPTH = 2**ADDR_W words.
- RD_MODE, 0: same-port read-during-write; 0 = read-first (old data), 1 = write-first (new data).
- OUT_REG, 0: 1 adds one output pipeline stage per port.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: single clock; all logic on the rising edge.
- rst, in, 1: asynchronous, active-low reset.
- en_a, in, 1: port A access enable.
- we_a, in, 1: port A write enable; qualified by en_a.
- addr_a, in, ADDR_W: port A address.
- din_a, in, DATA_W: port A write data.
- dout_a, out, DATA_W: port A read data.
- vld_a, out, 1: dout_a holds fresh read data this cycle.
- en_b, we_b, addr_b, din_b, dout_b, vld_b: port B, identical to port A.
- busy, out, 1: post-reset clear sequence in progress.
- coll, out, 1: one-cycle write-write collision pulse.

Function
REQ-003 Storage SHALL be DEPTH x DATA_W words, shared by both ports.
REQ-004 State machine SHALL have two states:
- CLEAR: entered on reset; a counter writes 0 to addresses 0..DEPTH-1, one per cycle; busy=1.
- RUN: entered after address DEPTH-1 is written; busy=0.
- CLEAR SHALL last exactly DEPTH cycles after reset release.
REQ-005 In CLEAR, all en_a/en_b requests SHALL be ignored: no write, no read, vld_a=vld_b=0, coll=0.
REQ-006 In RUN, en_x=1 and we_x=1 SHALL write din_x to addr_x at the clock edge.
REQ-007 In RUN, every en_x=1 access (read or write) SHALL produce a read of addr_x.
- OUT_REG=0: dout_x and vld_x=1 appear 1 cycle after the access.
- OUT_REG=1: dout_x and vld_x=1 appear 2 cycles after the access.
REQ-008 vld_x SHALL be 0 on any cycle without a corresponding access.
REQ-009 dout_x SHALL hold its last value while vld_x=0.
REQ-010 For a same-port write, the returned data SHALL be the previous word when RD_MODE=0 and din_x when RD_MODE=1.
REQ-011 For a cross-port read of an address written the same cycle by the other port, the reader SHALL return the previous word, regardless of RD_MODE.
REQ-012 For a write-write collision (both ports write the same address in the same cycle):
- port A data SHALL be stored; port B's write is dropped.
- coll SHALL be 1 on the following cycle only.
- port B's readback SHALL follow REQ-010 using din_b, the same as a non-colliding write.
REQ-013 Addresses SHALL be taken modulo DEPTH; there is no out-of-range behaviour.
REQ-014 Back-to-back accesses on every cycle SHALL be supported on both ports with no stall.

Reset
REQ-015 When rst=0 (asynchronous), the block SHALL immediately drive:
- dout_a=dout_b=0, vld_a=vld_b=0, coll=0, busy=1;
- pipeline registers cleared;
- clear counter=0;
- state=CLEAR.
REQ-016 Reset asserted mid-CLEAR or mid-RUN SHALL abort any in-flight reads (no vld pulse) and restart CLEAR from address 0 on release.
REQ-017 Memory contents SHALL be zero after CLEAR completes, regardless of prior contents.

Verification
REQ-018 Clear: release rst -> busy=1 for exactly 16 cycles (defaults); reading all 16 addresses afterwards returns 0x00.
REQ-019 Basic read/write: A writes 0x5A to addr 3, then B reads addr 3 -> dout_b=0x5A with vld_b=1 one cycle after B's access (OUT_REG=0), two cycles after (OUT_REG=1).
REQ-020 Read-during-write: addr 7 holds 0x11; A writes 0x22 to addr 7 while B reads addr 7 in the same cycle -> dout_a=0x11 (RD_MODE=0) or 0x22 (RD_MODE=1); dout_b=0x11 in both modes.
REQ-021 Collision: A writes 0xAA and B writes 0xBB to addr 9 in the same cycle -> coll=1 for exactly one cycle; a later read of addr 9 returns 0xAA.
REQ-022 Mid-operation reset: pull rst low while reads are in flight -> vld/dout/coll go to 0 without waiting for a clock edge; after release busy=1 for 16 cycles and all requests during CLEAR are ignored.
REQ-023 Streaming: both ports read consecutive addresses 0..15 every cycle -> 16 consecutive vld pulses per port with correct data and no gaps.
